grain_flex_prog_loader: RTL
===========================

GRAIN_FLEX_PROG_LOADER -- requirements
Module: grain_flex_prog_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 512, meaning the total configuration bits shifted per load (>=1).
REQ-002 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per prog_clk phase (>=1).
REQ-003 SHALL have parameter RST_CYCLES, default 4, meaning clk cycles prog_rst is held high at load start (>=1).
REQ-004 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle load request.
REQ-007 SHALL have ports s_data in 8, s_valid in 1, s_ready out 1: the bitstream byte stream.
REQ-008 SHALL have ports prog_clk out 1, prog_rst out 1, prog_en out 1, prog_din out 1: the drive side of the fabric programming chain.
REQ-009 SHALL have port prog_dout  in  1  chain serial output.
REQ-010 SHALL have ports busy out 1 and done out 1: status.

Function
REQ-011 SHALL implement states IDLE, CHAIN_RST, FETCH, SHIFT_LO, SHIFT_HI, FINISH.
REQ-012 SHALL leave IDLE for CHAIN_RST only on start=1; start SHALL be ignored in every other state.
REQ-013 CHAIN_RST SHALL drive prog_rst=1 for exactly RST_CYCLES cycles, then enter FETCH with bit counter cleared.
REQ-014 FETCH SHALL assert s_ready; a byte SHALL be accepted only on the cycle s_valid&s_ready=1, with s_ready dropping the following cycle.
REQ-015 Bits SHALL be shifted LSB first; a byte SHALL supply bits until 8 are used or CHAIN_LEN is reached, after which unused high bits are discarded.
REQ-016 SHALL hold prog_en=1 from the cycle after byte acceptance through the last SHIFT_HI.
REQ-017 SHIFT_LO SHALL hold prog_clk=0 and present the current bit on prog_din for CLK_DIV cycles; SHIFT_HI SHALL hold prog_clk=1 with prog_din stable for CLK_DIV cycles.
REQ-018 After SHIFT_HI: if CHAIN_LEN bits sent -> FINISH; else if byte bits remain -> SHIFT_LO; else -> FETCH.
REQ-019 FINISH SHALL drive prog_en=0 and prog_clk=0 for one cycle, pulse done=1 for exactly that cycle, then return to IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 s_valid low in FETCH SHALL stall with prog_clk held at 0 indefinitely; no prog_clk edges SHALL occur without data.
REQ-022 Bit counter SHALL be $clog2(CHAIN_LEN+1) bits wide and SHALL never wrap.

Reset
REQ-023 On reset=1 the block SHALL enter IDLE on the next clock edge, from any state, including mid-shift.
REQ-024 Reset values SHALL be: prog_clk=0, prog_rst=0, prog_en=0, prog_din=0, s_ready=0, busy=0, done=0; any partial byte SHALL be discarded.

Configuration
REQ-025 With macro PROG_READBACK_EN defined, SHALL add ports rb_data out 8, rb_valid out 1, rb_ready in 1, packing prog_dout, sampled in the last SHIFT_LO cycle, LSB first into bytes; a final partial byte SHALL be zero-padded and emitted before FINISH.
REQ-026 With PROG_READBACK_EN, a full readback byte with rb_ready=0 SHALL stall the transition into the next SHIFT_LO; rb_valid SHALL reset to 0.
REQ-027 Without PROG_READBACK_EN, the rb_* ports and logic SHALL be absent and prog_dout SHALL be unused.

Structure
REQ-028 A shared package grain_flex_prog_pkg SHALL hold the state enum typedef and the readback byte width constant (8).
REQ-029 A sub-module grain_flex_prog_clkgen SHALL implement the CLK_DIV phase counter, outputting a phase-done strobe.

Verification
REQ-030 CHAIN_LEN=16, CLK_DIV=2, bytes 0xA5,0x3C always valid -> prog_din sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 on 16 prog_clk rises, done pulses once, 2 bytes accepted.
REQ-031 CHAIN_LEN=12, byte 0xFF then 0x0F -> 12 rises, all ones, bits 12..15 of second byte dropped, third s_ready never asserted.
REQ-032 s_valid withheld 20 cycles after first byte -> prog_clk stays 0 throughout, shifted sequence unchanged, busy=1.
REQ-033 reset asserted during 5th SHIFT_HI -> next cycle all outputs at reset values; new start yields full RST_CYCLES=4 prog_rst pulse.
REQ-034 start pulsed while busy -> ignored, exactly one done per load.
REQ-035 PROG_READBACK_EN, CHAIN_LEN=8, chain model preloaded 0x96, input 0x00 -> rb_data=0x96 once; rb_ready low 10 cycles delays FINISH by 10 cycles.

Source files
------------

// File: rtl/grain_flex_prog_pkg.sv
// Shared types for the fabric programming loader: FSM state encoding and the
// readback byte width.
package grain_flex_prog_pkg;

   localparam int RB_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      CHAIN_RST,
      FETCH,
      SHIFT_LO,
      SHIFT_HI,
      FINISH
   } prog_state_e;

endpackage

// File: rtl/grain_flex_prog_clkgen.sv
// Phase timer for prog_clk: counts CLK_DIV cycles per phase while run is high
// and strobes phase_done on the final cycle; hold freezes the count.
module grain_flex_prog_clkgen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic hold,
   output logic phase_done
);

   localparam int CW = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;

   assign phase_done = run && (cnt == LAST);

   // A held strobe stays asserted so the FSM can leave the moment the stall clears.
   always_ff @(posedge clk) begin
      if (reset || !run)
         cnt <= '0;
      else if (!hold)
         cnt <= phase_done ? '0 : cnt + CW'(1);
   end

endmodule

// File: rtl/grain_flex_prog_loader.sv
// Serialises a byte stream LSB-first into the fabric configuration chain.
// Optional macro PROG_READBACK_EN adds a byte-packed readback of prog_dout.
module grain_flex_prog_loader
   import grain_flex_prog_pkg::*;
#(
   parameter int CHAIN_LEN  = 512,
   parameter int CLK_DIV    = 2,
   parameter int RST_CYCLES = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [7:0]      s_data,
   input  logic            s_valid,
   output logic            s_ready,
   output logic            prog_clk,
   output logic            prog_rst,
   output logic            prog_en,
   output logic            prog_din,
   input  logic            prog_dout,
   output logic            busy,
   output logic            done
`ifdef PROG_READBACK_EN
   ,
   output logic [RB_W-1:0] rb_data,
   output logic            rb_valid,
   input  logic            rb_ready
`endif
);

   localparam int BW  = $clog2(CHAIN_LEN + 1);
   localparam int RCW = $clog2(RST_CYCLES + 1);
   localparam logic [BW-1:0]  LAST_BIT = BW'(CHAIN_LEN - 1);
   localparam logic [RCW-1:0] LAST_RST = RCW'(RST_CYCLES - 1);

   prog_state_e    state;
   logic [BW-1:0]  bit_cnt;
   logic [RCW-1:0] rst_cnt;
   logic [7:0]     byte_q;
   logic [2:0]     byte_idx;
   logic [2:0]     nxt_idx;
   logic           phase_done;
   logic           stall;
   logic           last_bit;

   assign nxt_idx  = byte_idx + 3'd1;
   assign last_bit = (bit_cnt == LAST_BIT);

   grain_flex_prog_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .clk        (clk),
      .reset      (reset),
      .run        ((state == SHIFT_LO) || (state == SHIFT_HI)),
      .hold       ((state == SHIFT_HI) && stall),
      .phase_done (phase_done)
   );

`ifdef PROG_READBACK_EN
   logic [RB_W-1:0] rb_acc;
   logic [2:0]      rb_idx;

   // An unconsumed readback byte holds the chain in SHIFT_HI.
   assign stall = rb_valid && !rb_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         rb_data  <= '0;
         rb_valid <= 1'b0;
         rb_acc   <= '0;
         rb_idx   <= '0;
      end else begin
         if (rb_valid && rb_ready)
            rb_valid <= 1'b0;
         if (state == SHIFT_LO && phase_done) begin
            if (rb_idx == 3'd7 || last_bit) begin
               rb_data  <= rb_acc | (RB_W'(prog_dout) << rb_idx);
               rb_valid <= 1'b1;
               rb_acc   <= '0;
               rb_idx   <= '0;
            end else begin
               rb_acc[rb_idx] <= prog_dout;
               rb_idx         <= rb_idx + 3'd1;
            end
         end
      end
   end
`else
   logic unused_prog_dout;
   assign unused_prog_dout = prog_dout;
   assign stall = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         rst_cnt  <= '0;
         byte_q   <= '0;
         byte_idx <= '0;
         s_ready  <= 1'b0;
         prog_clk <= 1'b0;
         prog_rst <= 1'b0;
         prog_en  <= 1'b0;
         prog_din <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= CHAIN_RST;
                  prog_rst <= 1'b1;
                  busy     <= 1'b1;
                  rst_cnt  <= '0;
               end
            end
            CHAIN_RST: begin
               if (rst_cnt == LAST_RST) begin
                  state    <= FETCH;
                  prog_rst <= 1'b0;
                  s_ready  <= 1'b1;
                  bit_cnt  <= '0;
               end else begin
                  rst_cnt <= rst_cnt + RCW'(1);
               end
            end
            FETCH: begin
               if (s_valid && s_ready) begin
                  state    <= SHIFT_LO;
                  byte_q   <= s_data;
                  byte_idx <= '0;
                  s_ready  <= 1'b0;
                  prog_en  <= 1'b1;
                  prog_din <= s_data[0];
               end
            end
            SHIFT_LO: begin
               if (phase_done) begin
                  state    <= SHIFT_HI;
                  prog_clk <= 1'b1;
               end
            end
            SHIFT_HI: begin
               if (phase_done && !stall) begin
                  prog_clk <= 1'b0;
                  bit_cnt  <= bit_cnt + BW'(1);
                  if (last_bit) begin
                     // Remaining high bits of the current byte are dropped here.
                     state    <= FINISH;
                     prog_en  <= 1'b0;
                     prog_din <= 1'b0;
                     done     <= 1'b1;
                  end else if (byte_idx != 3'd7) begin
                     state    <= SHIFT_LO;
                     byte_idx <= nxt_idx;
                     prog_din <= byte_q[nxt_idx];
                  end else begin
                     state   <= FETCH;
                     s_ready <= 1'b1;
                  end
               end
            end
            FINISH: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
